// File: rtl/mem_1r1w_masked_48x64_fifo.sv
// Valid/ready FIFO controller for the 48x64 1R1W masked macro. A 2-entry output
// buffer hides the macro's 1-cycle read latency so both sides sustain full rate.
module mem_1r1w_masked_48x64_fifo #(
  parameter int unsigned Depth = 48,
  parameter int unsigned Width = 64,
  parameter int unsigned AddrW = 6,
  parameter int unsigned MaskW = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [Width-1:0] enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [Width-1:0] deq_data,
  output logic [AddrW-1:0] count,
  output logic [AddrW-1:0] mem_waddr,
  output logic             mem_wen,
  output logic [Width-1:0] mem_wdata,
  output logic [MaskW-1:0] mem_wmask,
  output logic [AddrW-1:0] mem_raddr,
  output logic             mem_ren,
  input  logic [Width-1:0] mem_rdata
);
  localparam logic [AddrW-1:0] DepthA = AddrW'(Depth);
  localparam logic [AddrW-1:0] LastA  = AddrW'(Depth - 1);

  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW-1:0] mem_cnt_q, mem_cnt_d;
  logic [AddrW-1:0] count_q, count_d;
  logic             rd_pend_q, rd_pend_d;
  logic [1:0]       ob_cnt_q, ob_cnt_d;
  logic             ob_hd_q, ob_hd_d;
  logic [Width-1:0] ob_q [2];
  logic [Width-1:0] ob_d [2];
  logic             active, enq_fire, deq_fire;
  logic [2:0]       ob_need;

  // Output-side decodes; everything is held off while in reset or flushing.
  always_comb begin
    active    = reset_n && !flush;
    enq_ready = active && (count_q < DepthA);
    deq_valid = active && (ob_cnt_q != 2'd0);
    enq_fire  = enq_valid && enq_ready;
    deq_fire  = deq_valid && deq_ready;
    deq_data  = ob_q[ob_hd_q];

    // Buffer slots already claimed once this cycle's pop and the in-flight read settle.
    ob_need   = {1'b0, ob_cnt_q} + {2'b00, rd_pend_q} - {2'b00, deq_fire};

    mem_wen   = enq_fire;
    mem_waddr = wr_ptr_q;
    mem_wdata = enq_data;
    mem_wmask = {MaskW{enq_fire}};
    mem_ren   = active && (mem_cnt_q != '0) && (ob_need < 3'd2);
    mem_raddr = rd_ptr_q;
    count     = count_q;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ob_d      = ob_q;
    rd_pend_d = mem_ren;
    ob_hd_d   = ob_hd_q ^ deq_fire;
    mem_cnt_d = mem_cnt_q + AddrW'(enq_fire) - AddrW'(mem_ren);
    ob_cnt_d  = ob_cnt_q + 2'(rd_pend_q) - 2'(deq_fire);

    if (enq_fire) begin
      wr_ptr_d = (wr_ptr_q == LastA) ? '0 : wr_ptr_q + 1'b1;
    end
    if (mem_ren) begin
      rd_ptr_d = (rd_ptr_q == LastA) ? '0 : rd_ptr_q + 1'b1;
    end
    // Returning read data lands at the tail (head + occupancy, modulo 2).
    if (rd_pend_q) begin
      ob_d[ob_hd_q ^ ob_cnt_q[0]] = mem_rdata;
    end

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      mem_cnt_d = '0;
      rd_pend_d = 1'b0;
      ob_cnt_d  = 2'd0;
      ob_hd_d   = 1'b0;
    end

    count_d = mem_cnt_d + AddrW'(rd_pend_d) + AddrW'(ob_cnt_d);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      count_q   <= '0;
      rd_pend_q <= 1'b0;
      ob_cnt_q  <= 2'd0;
      ob_hd_q   <= 1'b0;
      ob_q[0]   <= '0;
      ob_q[1]   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_cnt_q <= mem_cnt_d;
      count_q   <= count_d;
      rd_pend_q <= rd_pend_d;
      ob_cnt_q  <= ob_cnt_d;
      ob_hd_q   <= ob_hd_d;
      ob_q      <= ob_d;
    end
  end

endmodule

// File: tb/tb_mem_1r1w_masked_48x64_fifo.sv
// Scoreboard bench for the 48x64 FIFO controller with a behavioural macro model.
module tb_mem_1r1w_masked_48x64_fifo;
  logic        clock = 1'b0;
  logic        reset_n, flush, enq_valid, enq_ready, deq_valid, deq_ready;
  logic [63:0] enq_data, deq_data, mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic [5:0]  count, mem_waddr, mem_raddr;
  logic        mem_wen, mem_ren;
  logic [7:0]  mem_wmask;

  int          checks = 0;
  int          errors = 0;
  int          occ = 0;
  bit          mon_en = 1'b0;
  bit          stall = 1'b0;
  logic [63:0] stall_data = '0;
  logic [63:0] exp_q[$];
  logic [63:0] mem_m [48];

  always #5 clock = ~clock;

  mem_1r1w_masked_48x64_fifo dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_data  (enq_data),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_data  (deq_data),
    .count     (count),
    .mem_waddr (mem_waddr),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_raddr (mem_raddr),
    .mem_ren   (mem_ren),
    .mem_rdata (mem_rdata)
  );

  // Macro model: byte-masked write, registered read.
  always @(posedge clock) begin
    if (mem_wen && mem_waddr < 6'd48) begin
      for (int b = 0; b < 8; b++) begin
        if (mem_wmask[b]) mem_m[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
    if (mem_ren && mem_raddr < 6'd48) mem_rdata <= mem_m[mem_raddr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: occupancy model, ordered scoreboard, stall stability.
  always @(negedge clock) begin
    if (mon_en) begin
      if (reset_n) chk("count", 64'(count), 64'(occ));
      if (stall && reset_n && !flush) begin
        chk("stall_valid", 64'(deq_valid), 64'd1);
        chk("stall_data", deq_data, stall_data);
      end
      if (deq_valid && deq_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deq_extra actual=%h required=none", deq_data);
        end else begin
          chk("deq_data", deq_data, exp_q.pop_front());
        end
        occ--;
      end
      if (enq_valid && enq_ready) begin
        exp_q.push_back(enq_data);
        occ++;
      end
      if (flush || !reset_n) begin
        exp_q.delete();
        occ   = 0;
        stall = 1'b0;
      end else begin
        stall      = deq_valid && !deq_ready;
        stall_data = deq_data;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_empty();
    int n = 0;
    @(negedge clock);
    while ((count != 6'd0 || deq_valid) && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("drain_count", 64'(count), 64'd0);
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    enq_valid = 1'b1;
    deq_ready = 1'b1;
    enq_data  = 64'h1;

    // Reset held for 3 edges; strobes must stay quiet even with requests high.
    step();
    @(negedge clock);
    chk("rst_enq_ready", 64'(enq_ready), 64'd0);
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_mem_wen", 64'(mem_wen), 64'd0);
    chk("rst_mem_ren", 64'(mem_ren), 64'd0);
    step();
    step();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    reset_n   = 1'b1;
    mon_en    = 1'b1;
    @(negedge clock);
    chk("rel_enq_ready", 64'(enq_ready), 64'd1);
    chk("rel_deq_valid", 64'(deq_valid), 64'd0);
    chk("rel_mem_wen", 64'(mem_wen), 64'd0);
    chk("rel_mem_ren", 64'(mem_ren), 64'd0);
    chk("rel_waddr", 64'(mem_waddr), 64'd0);
    chk("rel_raddr", 64'(mem_raddr), 64'd0);
    chk("rel_wmask", 64'(mem_wmask), 64'd0);
    chk("rel_deq_data", deq_data, 64'd0);

    // Single word latency.
    step();
    enq_valid = 1'b1;
    enq_data  = 64'hDEADBEEF_00000001;
    @(negedge clock);
    chk("sw_wen", 64'(mem_wen), 64'd1);
    chk("sw_waddr", 64'(mem_waddr), 64'd0);
    chk("sw_wmask", 64'(mem_wmask), 64'hFF);
    chk("sw_wdata", mem_wdata, 64'hDEADBEEF_00000001);
    step();
    enq_valid = 1'b0;
    @(negedge clock);
    chk("sw_ren", 64'(mem_ren), 64'd1);
    chk("sw_raddr", 64'(mem_raddr), 64'd0);
    step();
    @(negedge clock);
    chk("sw_c2_valid", 64'(deq_valid), 64'd0);
    chk("sw_c2_ren", 64'(mem_ren), 64'd0);
    step();
    deq_ready = 1'b1;
    @(negedge clock);
    chk("sw_c3_valid", 64'(deq_valid), 64'd1);
    chk("sw_c3_data", deq_data, 64'hDEADBEEF_00000001);
    step();
    deq_ready = 1'b0;
    @(negedge clock);
    chk("sw_after_count", 64'(count), 64'd0);
    chk("sw_after_valid", 64'(deq_valid), 64'd0);
    step();

    // Fill to capacity; write address wraps 47 -> 0 on the last word.
    for (int i = 0; i < 48; i++) begin
      enq_valid = 1'b1;
      enq_data  = 64'h1000 + 64'(i);
      @(negedge clock);
      chk("fill_ready", 64'(enq_ready), 64'd1);
      chk("fill_waddr", 64'(mem_waddr), 64'((i + 1) % 48));
      step();
    end
    enq_data = 64'hBAD;
    @(negedge clock);
    chk("full_ready", 64'(enq_ready), 64'd0);
    chk("full_count", 64'(count), 64'd48);
    chk("full_wen", 64'(mem_wen), 64'd0);
    step();
    enq_valid = 1'b0;
    repeat (4) step();
    deq_ready = 1'b1;
    @(negedge clock);
    chk("full_deq_valid", 64'(deq_valid), 64'd1);
    chk("full_no_bypass", 64'(enq_ready), 64'd0);
    step();
    @(negedge clock);
    chk("full_ready_back", 64'(enq_ready), 64'd1);
    step();
    wait_empty();
    for (int j = 0; j < 10; j++) begin
      enq_valid = 1'b1;
      enq_data  = 64'h2000 + 64'(j);
      @(negedge clock);
      chk("wrap_waddr", 64'(mem_waddr), 64'((49 + j) % 48));
      step();
    end
    enq_valid = 1'b0;
    wait_empty();

    // Streaming at full rate.
    deq_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      enq_valid = 1'b1;
      enq_data  = 64'h5000 + 64'(i);
      @(negedge clock);
      chk("stream_ready", 64'(enq_ready), 64'd1);
      if (i >= 3) begin
        chk("stream_valid", 64'(deq_valid), 64'd1);
        chk("stream_count", 64'(count), 64'd3);
      end
      step();
    end
    enq_valid = 1'b0;
    wait_empty();

    // Random backpressure.
    for (int i = 0; i < 300; i++) begin
      enq_valid = ($urandom_range(0, 9) < 7);
      deq_ready = ($urandom_range(0, 1) == 1);
      enq_data  = {$urandom, $urandom};
      step();
    end
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    wait_empty();

    // Flush with entries stored and a read in flight.
    deq_ready = 1'b0;
    for (int i = 0; i < 21; i++) begin
      enq_valid = 1'b1;
      enq_data  = 64'h7000 + 64'(i);
      @(negedge clock);
      chk("fl_fill_ready", 64'(enq_ready), 64'd1);
      step();
    end
    enq_valid = 1'b0;
    repeat (3) step();
    deq_ready = 1'b1;
    @(negedge clock);
    chk("fl_read_issue", 64'(mem_ren), 64'd1);
    step();
    deq_ready = 1'b0;
    flush     = 1'b1;
    @(negedge clock);
    chk("fl_enq_ready", 64'(enq_ready), 64'd0);
    chk("fl_deq_valid", 64'(deq_valid), 64'd0);
    chk("fl_ren", 64'(mem_ren), 64'd0);
    step();
    flush = 1'b0;
    @(negedge clock);
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_after_valid", 64'(deq_valid), 64'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("fl_stay_empty", 64'(deq_valid), 64'd0);
      step();
    end
    enq_valid = 1'b1;
    enq_data  = 64'h8000;
    @(negedge clock);
    chk("fl_next_waddr", 64'(mem_waddr), 64'd0);
    chk("fl_next_wen", 64'(mem_wen), 64'd1);
    step();
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    wait_empty();

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
